// File: rtl/fpu_pkg.sv
// Shared FP issue definitions: decoder ALU codes, FSM states and default latencies.
package fpu_pkg;

  localparam logic [3:0] ALU_FADD  = 4'b1000;
  localparam logic [3:0] ALU_FSUB  = 4'b1001;
  localparam logic [3:0] ALU_FMUL  = 4'b1010;
  localparam logic [3:0] ALU_FDIV  = 4'b1011;
  localparam logic [3:0] ALU_FSQRT = 4'b1100;

  localparam int DEF_LAT_ADDSUB = 2;
  localparam int DEF_LAT_MUL    = 2;
  localparam int DEF_LAT_DIV    = 10;
  localparam int DEF_LAT_SQRT   = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fpu_state_t;

  // True for the five FP codes the datapath implements; 1101..1111 are reserved.
  function automatic logic is_fp_legal(input logic [3:0] code);
    logic ok;
    ok = 1'b0;
    case (code)
      ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FDIV, ALU_FSQRT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// 4-bit latency down-counter; 'last' marks the cycle the datapath result is valid.
module fpu_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       last
);

  // Load takes priority so a new launch always restarts the count; stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign last = (count == 4'd1);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: holds the pipeline while a multi-cycle FP op runs, then writes back.
module fpu_issue_ctrl #(
  parameter int LAT_ADDSUB = fpu_pkg::DEF_LAT_ADDSUB,
  parameter int LAT_MUL    = fpu_pkg::DEF_LAT_MUL,
  parameter int LAT_DIV    = fpu_pkg::DEF_LAT_DIV,
  parameter int LAT_SQRT   = fpu_pkg::DEF_LAT_SQRT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  alu_cont_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  input  logic [31:0] fpu_result_i,
  output logic        start_o,
  output logic [3:0]  op_o,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic        stall_o,
  output logic        illegal_o,
  output logic        wb_valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  import fpu_pkg::*;

  fpu_state_t state;
  logic [4:0] rd_q;
  logic       wb_q;
  logic       code_legal;
  logic       accept;
  logic [3:0] lat_sel;
  logic [3:0] cnt_value;
  logic       cnt_last;

  assign code_legal = is_fp_legal(alu_cont_i);
  assign accept     = !rst && (state == ST_IDLE) && valid_i && !flush_i && code_legal;

  // Pick the load value for the latency counter from the incoming op.
  always_comb begin
    lat_sel = 4'd1;
    case (alu_cont_i)
      ALU_FADD, ALU_FSUB: lat_sel = 4'(LAT_ADDSUB);
      ALU_FMUL:           lat_sel = 4'(LAT_MUL);
      ALU_FDIV:           lat_sel = 4'(LAT_DIV);
      ALU_FSQRT:          lat_sel = 4'(LAT_SQRT);
      default:            lat_sel = 4'd1;
    endcase
  end

  fpu_lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (lat_sel),
    .dec      (state == ST_BUSY),
    .count    (cnt_value),
    .last     (cnt_last)
  );

  // Main FSM: latch the op on accept, wait out the latency, capture and write back once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      start_o  <= 1'b0;
      op_o     <= 4'd0;
      src1_o   <= 32'd0;
      src2_o   <= 32'd0;
      result_o <= 32'd0;
      rd_o     <= 5'd0;
      rd_q     <= 5'd0;
      wb_q     <= 1'b0;
    end else begin
      start_o <= accept;
      wb_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_o   <= alu_cont_i;
            src1_o <= rs1_i;
            src2_o <= rs2_i;
            rd_q   <= rd_i;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (cnt_last) begin
            result_o <= fpu_result_i;
            rd_o     <= rd_q;
            wb_q     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A flush or reset in the writeback cycle kills the write.
  assign wb_valid_o = wb_q && !flush_i && !rst;

  // Hold the pipeline while accepting and while busy; a flush releases it immediately.
  assign stall_o = !rst && !flush_i && (accept || (state == ST_BUSY));

  assign illegal_o = !rst && (state == ST_IDLE) && valid_i && alu_cont_i[3] && !code_legal;

  logic unused_ok;
  assign unused_ok = ^cnt_value;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed scoreboard bench for fpu_issue_ctrl with a fixed-latency datapath model.
module tb_fpu_issue_ctrl;

  localparam logic [3:0] C_FADD  = 4'b1000;
  localparam logic [3:0] C_FSUB  = 4'b1001;
  localparam logic [3:0] C_FMUL  = 4'b1010;
  localparam logic [3:0] C_FDIV  = 4'b1011;
  localparam logic [3:0] C_FSQRT = 4'b1100;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  alu_cont_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic [31:0] fpu_result_i;
  logic        start_o;
  logic [3:0]  op_o;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic        stall_o;
  logic        illegal_o;
  logic        wb_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wb_seen = 0;
  int   dp_rem = 0;
  logic [31:0] dp_val;

  fpu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .alu_cont_i   (alu_cont_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .rd_i         (rd_i),
    .flush_i      (flush_i),
    .fpu_result_i (fpu_result_i),
    .start_o      (start_o),
    .op_o         (op_o),
    .src1_o       (src1_o),
    .src2_o       (src2_o),
    .stall_o      (stall_o),
    .illegal_o    (illegal_o),
    .wb_valid_o   (wb_valid_o),
    .result_o     (result_o),
    .rd_o         (rd_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latOf(input logic [3:0] code);
    case (code)
      C_FADD, C_FSUB: return 2;
      C_FMUL:         return 2;
      C_FDIV:         return 10;
      C_FSQRT:        return 12;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [31:0] modelResult(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    if (code == C_FADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + {28'd0, code};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] code, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    valid_i    = v;
    alu_cont_i = code;
    rs1_i      = a;
    rs2_i      = b;
    rd_i       = rd;
  endtask

  // Datapath model: result valid only in the cycle LAT after start, garbage otherwise.
  always @(negedge clk) begin
    if (start_o === 1'b1) begin
      dp_rem = latOf(op_o);
      dp_val = modelResult(op_o, src1_o, src2_o);
    end
    fpu_result_i = (dp_rem == 1) ? dp_val : 32'hDEADBEEF;
    if (dp_rem > 0) dp_rem = dp_rem - 1;
  end

  // Scoreboard: every writeback must match the oldest pending instruction.
  always @(negedge clk) begin
    exp_t e;
    if (wb_valid_o === 1'b1) begin
      wb_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_wb observed=1 expected=0 rd=%0d", rd_o);
      end else begin
        e = sb.pop_front();
        checkOutput("wb_rd", 32'(rd_o), 32'(e.rd));
        checkOutput("wb_result", result_o, e.res);
        checkOutput("wb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, hold valid_i through DONE, and check stall/start/op timing cycle by cycle.
  task automatic runOp(input string tag, input logic [3:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int   t0;
    int   wb0;
    int   lat;
    exp_t e;
    lat = latOf(code);
    t0  = cyc;
    wb0 = wb_seen;
    applyStimulus(1'b1, code, a, b, rd);
    e.rd  = rd;
    e.res = modelResult(code, a, b);
    e.cyc = t0 + lat + 1;
    sb.push_back(e);
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      checkOutput({tag, "_stall"}, 32'(stall_o), (k <= lat) ? 32'd1 : 32'd0);
      checkOutput({tag, "_start"}, 32'(start_o), (k == 1) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= lat) begin
        checkOutput({tag, "_op"}, 32'(op_o), 32'(code));
        checkOutput({tag, "_src1"}, src1_o, a);
        checkOutput({tag, "_src2"}, src2_o, b);
      end
      stepCycle();
    end
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    checkOutput({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, "_idle_start"}, 32'(start_o), 32'd0);
    checkOutput({tag, "_wb_count"}, 32'(wb_seen - wb0), 32'd1);
    checkOutput({tag, "_hold_result"}, result_o, e.res);
    checkOutput({tag, "_hold_rd"}, 32'(rd_o), 32'(rd));
    stepCycle();
  endtask

  initial begin
    int wb0;
    rst     = 1'b1;
    flush_i = 1'b0;
    fpu_result_i = 32'hDEADBEEF;
    applyStimulus(1'b1, C_FADD, 32'h1, 32'h2, 5'd3);

    // Reset: stall/illegal forced low while rst is high, registers cleared after.
    stepCycle();
    @(negedge clk);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    checkOutput("rst_illegal", 32'(illegal_o), 32'd0);
    applyStimulus(1'b1, 4'b1110, 32'h1, 32'h2, 5'd3);
    @(negedge clk);
    checkOutput("rst_illegal_code", 32'(illegal_o), 32'd0);
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
    stepCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_start", 32'(start_o), 32'd0);
    checkOutput("rst_wb", 32'(wb_valid_o), 32'd0);
    checkOutput("rst_op", 32'(op_o), 32'd0);
    checkOutput("rst_src1", src1_o, 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_rd", 32'(rd_o), 32'd0);
    stepCycle();

    runOp("fadd", C_FADD, 32'h3F800000, 32'h40000000, 5'd5);
    runOp("fsub", C_FSUB, 32'h12345678, 32'h0F0F0F0F, 5'd9);
    runOp("fmul", C_FMUL, 32'hCAFEF00D, 32'h00C0FFEE, 5'd17);
    runOp("fdiv", C_FDIV, 32'h41200000, 32'h40A00000, 5'd21);
    runOp("fsqrt", C_FSQRT, 32'h41800000, 32'h0, 5'd31);

    // Reserved FP code: one-cycle illegal pulse, no launch, no stall.
    applyStimulus(1'b1, 4'b1101, 32'h1, 32'h2, 5'd4);
    @(negedge clk);
    checkOutput("ill_flag", 32'(illegal_o), 32'd1);
    checkOutput("ill_stall", 32'(stall_o), 32'd0);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    checkOutput("ill_flag_off", 32'(illegal_o), 32'd0);
    checkOutput("ill_start", 32'(start_o), 32'd0);
    stepCycle();

    // Non-FP code: ignored entirely.
    applyStimulus(1'b1, 4'b0000, 32'h5, 32'h6, 5'd4);
    @(negedge clk);
    checkOutput("int_illegal", 32'(illegal_o), 32'd0);
    checkOutput("int_stall", 32'(stall_o), 32'd0);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    checkOutput("int_start", 32'(start_o), 32'd0);
    checkOutput("int_wb", 32'(wb_valid_o), 32'd0);
    stepCycle();

    // Flush at T+4 of an fdiv: stall drops at once, IDLE next cycle, no writeback.
    wb0 = wb_seen;
    applyStimulus(1'b1, C_FDIV, 32'h11111111, 32'h22222222, 5'd12);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("flush_pre_stall", 32'(stall_o), 32'd1);
      stepCycle();
    end
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", 32'(stall_o), 32'd0);
    checkOutput("flush_wb", 32'(wb_valid_o), 32'd0);
    stepCycle();
    flush_i = 1'b0;
    applyStimulus(1'b1, 4'b1111, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    checkOutput("flush_idle_ill", 32'(illegal_o), 32'd1);
    checkOutput("flush_idle_stall", 32'(stall_o), 32'd0);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
    repeat (14) @(negedge clk);
    checkOutput("flush_no_wb", 32'(wb_seen - wb0), 32'd0);
    stepCycle();

    // Reset at T+3 of an fsqrt: everything clears, next fmul runs normally.
    wb0 = wb_seen;
    applyStimulus(1'b1, C_FSQRT, 32'h33333333, 32'h0, 5'd8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rstm_pre_stall", 32'(stall_o), 32'd1);
      stepCycle();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstm_stall", 32'(stall_o), 32'd0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    checkOutput("rstm_start", 32'(start_o), 32'd0);
    checkOutput("rstm_wb", 32'(wb_valid_o), 32'd0);
    checkOutput("rstm_op", 32'(op_o), 32'd0);
    checkOutput("rstm_src1", src1_o, 32'd0);
    checkOutput("rstm_src2", src2_o, 32'd0);
    checkOutput("rstm_result", result_o, 32'd0);
    checkOutput("rstm_rd", 32'(rd_o), 32'd0);
    checkOutput("rstm_stall_after", 32'(stall_o), 32'd0);
    stepCycle();
    runOp("fmul_after_rst", C_FMUL, 32'h3F800000, 32'h40400000, 5'd14);
    repeat (14) @(negedge clk);
    checkOutput("rstm_wb_total", 32'(wb_seen - wb0), 32'd1);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
